// File: rtl/mul_result_fifo.sv
// First-word-fall-through result/flag buffer between the multiplier and writeback.
// Define MUL_FIFO_STICKY_FLAGS_EN to build the sticky exception-flag accumulator.
module mul_result_fifo #(
  parameter int bus   = 4,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [bus-1:0]           result,
  input  logic                     overflow,
  input  logic                     zero,
  input  logic                     negative,
  input  logic                     carry_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [bus-1:0]           out_result,
  output logic [3:0]               out_flags,
  output logic [$clog2(depth):0]   count,
  input  logic                     clear_sticky,
  output logic [3:0]               sticky_flags
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam int EW = bus + 4;

  logic [EW-1:0] mem_q [depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_s;
  logic          pop_s;
  logic [3:0]    in_flags_s;
  logic [EW-1:0] head_s;

  assign in_flags_s = {overflow, zero, negative, carry_out};

  // in_ready deliberately ignores out_ready: a full FIFO never accepts on a same-cycle pop.
  assign in_ready  = !rst && (count_q < CW'(depth));
  assign out_valid = (count_q != {CW{1'b0}});
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready && !rst;

  assign head_s     = mem_q[rd_ptr_q];
  assign out_result = out_valid ? head_s[EW-1:4] : {bus{1'b0}};
  assign out_flags  = out_valid ? head_s[3:0]    : 4'b0000;
  assign count      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left uninitialised by reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {result, in_flags_s};
    end
  end

`ifdef MUL_FIFO_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (clear_sticky && push_s) begin
      sticky_d = in_flags_s;
    end else if (clear_sticky) begin
      sticky_d = 4'b0000;
    end else if (push_s) begin
      sticky_d = sticky_q | in_flags_s;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 4'b0000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_clear_sticky_s;
  assign unused_clear_sticky_s = clear_sticky;
  assign sticky_flags          = 4'b0000;
`endif

endmodule

// File: tb/tb_mul_result_fifo.sv
// Directed vector-table bench for mul_result_fifo (bus=4, depth=4).
module tb_mul_result_fifo;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] result;
  logic       overflow, zero, negative, carry_out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [2:0] count;
  logic       clear_sticky;
  logic [3:0] sticky_flags;

  int n_checks;
  int n_fail;

  mul_result_fifo #(.bus(4), .depth(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .result       (result),
    .overflow     (overflow),
    .zero         (zero),
    .negative     (negative),
    .carry_out    (carry_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .count        (count),
    .clear_sticky (clear_sticky),
    .sticky_flags (sticky_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] res;
    logic [3:0] flg;
    logic       ordy;
    logic       clr;
    logic [2:0] cnt;
    logic       ov;
    logic [3:0] ores;
    logic [3:0] oflg;
    logic       ir;
    logic [3:0] st;
  } vec_t;

  vec_t tbl [0:25];

  function automatic vec_t mk(input logic r, input logic iv, input logic [3:0] res,
                              input logic [3:0] flg, input logic ordy, input logic clr,
                              input logic [2:0] cnt, input logic ov, input logic [3:0] ores,
                              input logic [3:0] oflg, input logic ir, input logic [3:0] st);
    vec_t v;
    v.rst = r; v.iv = iv; v.res = res; v.flg = flg; v.ordy = ordy; v.clr = clr;
    v.cnt = cnt; v.ov = ov; v.ores = ores; v.oflg = oflg; v.ir = ir; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] res, input logic [3:0] flg,
                       input logic ordy, input logic clr);
    rst = r; in_valid = iv; result = res;
    {overflow, zero, negative, carry_out} = flg;
    out_ready = ordy; clear_sticky = clr;
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic run_rows(input int lo, input int hi);
    logic [3:0] exp_st;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].iv, tbl[i].res, tbl[i].flg, tbl[i].ordy, tbl[i].clr);
      #1;
`ifdef MUL_FIFO_STICKY_FLAGS_EN
      exp_st = tbl[i].st;
`else
      exp_st = 4'b0000;
`endif
      check("count",        i, 32'(count),        32'(tbl[i].cnt));
      check("out_valid",    i, 32'(out_valid),    32'(tbl[i].ov));
      check("out_result",   i, 32'(out_result),   32'(tbl[i].ores));
      check("out_flags",    i, 32'(out_flags),    32'(tbl[i].oflg));
      check("in_ready",     i, 32'(in_ready),     32'(tbl[i].ir));
      check("sticky_flags", i, 32'(sticky_flags), 32'(exp_st));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // Columns: rst iv res flg ordy clr | cnt ov ores oflg ir st (state before this cycle's edge)
    tbl[0]  = mk(1'b1, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
    tbl[1]  = mk(1'b1, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
    tbl[2]  = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    tbl[3]  = mk(1'b0, 1'b1, 4'hF, 4'h2, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    tbl[4]  = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 4'hF, 4'h2, 1'b1, 4'h2);
    tbl[5]  = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 4'hF, 4'h2, 1'b1, 4'h2);
    tbl[6]  = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h2);
    tbl[7]  = mk(1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h2);
    tbl[8]  = mk(1'b0, 1'b1, 4'h2, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 4'h1, 4'h0, 1'b1, 4'h2);
    tbl[9]  = mk(1'b0, 1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 3'd2, 1'b1, 4'h1, 4'h0, 1'b1, 4'h2);
    tbl[10] = mk(1'b0, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0, 3'd3, 1'b1, 4'h1, 4'h0, 1'b1, 4'h2);
    tbl[11] = mk(1'b0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 3'd4, 1'b1, 4'h1, 4'h0, 1'b0, 4'h2);
    tbl[12] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 3'd4, 1'b1, 4'h1, 4'h0, 1'b0, 4'h2);
    tbl[13] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 3'd3, 1'b1, 4'h2, 4'h0, 1'b1, 4'h2);
    tbl[14] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 3'd2, 1'b1, 4'h3, 4'h0, 1'b1, 4'h2);
    tbl[15] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 4'h4, 4'h0, 1'b1, 4'h2);
    tbl[16] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h2);
    tbl[17] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 4'h9, 4'h0, 1'b1, 4'h2);
    tbl[18] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h2);
    tbl[19] = mk(1'b0, 1'b1, 4'h7, 4'h8, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    tbl[20] = mk(1'b0, 1'b1, 4'h8, 4'h4, 1'b0, 1'b0, 3'd1, 1'b1, 4'h7, 4'h8, 1'b1, 4'h8);
    tbl[21] = mk(1'b0, 1'b1, 4'h9, 4'h1, 1'b0, 1'b1, 3'd2, 1'b1, 4'h7, 4'h8, 1'b1, 4'hC);
    tbl[22] = mk(1'b1, 1'b1, 4'hE, 4'hF, 1'b1, 1'b0, 3'd3, 1'b1, 4'h7, 4'h8, 1'b0, 4'h1);
    tbl[23] = mk(1'b0, 1'b1, 4'hA, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
    tbl[24] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 4'hA, 4'h0, 1'b1, 4'h0);
    tbl[25] = mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0);

    drive(1'b1, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0);
    @(posedge clk);

    // Reset, single entry, fill and drain.
    run_rows(0, 16);

    // Streaming push+pop across several pointer wraps.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 4'(k), 4'h0, 1'b1, 1'b0);
      #1;
      check("wrap_count",     k, 32'(count),      (k == 0) ? 32'd0 : 32'd1);
      check("wrap_out_valid", k, 32'(out_valid),  (k == 0) ? 32'd0 : 32'd1);
      check("wrap_out",       k, 32'(out_result), (k == 0) ? 32'd0 : 32'(k - 1));
      check("wrap_in_ready",  k, 32'(in_ready),   32'd1);
    end

    // Tail of the wrap stream, sticky sequence, reset mid-operation.
    run_rows(17, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_result_fifo.md
# mul_result_fifo

Buffers the result and flag outputs of the combinational multiplier so the multiply stage can hand off products to the writeback stage under a valid/ready handshake. It is a first-word-fall-through FIFO of `{result, overflow, zero, negative, carry_out}` entries with an occupancy counter. It also has an optional sticky flag register that accumulates exceptions across a sequence of products. It sits directly downstream of the multiplier and upstream of the register-file writeback.

## Interface
- `bus`, 4, data width; must match the multiplier's `bus`.
- `depth`, 4, number of entries; power of two, at least 2.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  multiplier output holds a product to store.
- `in_ready`  out  1  FIFO can accept an entry this cycle.
- `result`  in  bus  product from the multiplier.
- `overflow`, `zero`, `negative`, `carry_out`  in  1 each  flags from the multiplier.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer takes the head entry this cycle.
- `out_result`  out  bus  head entry result.
- `out_flags`  out  4  head entry flags `{overflow, zero, negative, carry_out}`.
- `count`  out  $clog2(depth)+1  number of stored entries.
- `clear_sticky`  in  1  clears the sticky flags.
- `sticky_flags`  out  4  OR of the flags of every entry pushed since the last clear or reset.

## Operation
- **Push:** occurs when `in_valid && in_ready`. The 4-bit flag vector is packed in `out_flags` order and written at `wr_ptr`; `wr_ptr` then increments modulo `depth`.
- **Pop:** occurs when `out_valid && out_ready`; `rd_ptr` then increments modulo `depth`.
- **Handshake signals:**
  - `in_ready = !rst && (count < depth)`.
  - `out_valid = (count != 0)`.
  - `in_ready` does not depend on `out_ready`, so a full FIFO never pass-through accepts.
- **Count update:**
  - Push only: `count + 1`.
  - Pop only: `count - 1`.
  - Push and pop in the same cycle: `count` unchanged. This is legal whenever `0 < count < depth`.
- **Pointer wrap-around:** the pointers wrap without discontinuity. The entry order seen at the output always equals push order.
- **Empty state:** `out_result` and `out_flags` are driven to 0 whenever `out_valid` = 0.
- **Head data:** when non-empty, `out_result` and `out_flags` are the registered head entry. There is no combinational path from the `result` and flag inputs to the outputs.
- **Input protocol:** the producer must hold its inputs stable while `in_valid && !in_ready`. The FIFO does not check this.
- **Sticky flags:** `sticky_flags` is updated on every push as `sticky | pushed_flags`.
  - `clear_sticky` without a push: `sticky` becomes 0.
  - `clear_sticky` and a push in the same cycle: `sticky` becomes `pushed_flags` (the new entry wins).
- **Reset:** reset while non-empty discards all stored entries.

## Timing
- **While `rst` is high, at each clock edge:**
  - `count` = 0, `wr_ptr` = 0, `rd_ptr` = 0, `sticky_flags` = 0.
  - Data storage is not cleared.
- **Outputs after reset:**
  - `out_valid` = 0, `out_result` = 0, `out_flags` = 0.
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after `rst` falls.
- **Latency:** 1 cycle. A push at edge N gives `out_valid` = 1 and the data at the head after edge N.
- **Throughput:** 1 entry per cycle in each direction.
- **Full state:** when `count == depth`, `in_ready` = 0 in the same cycle (it is decoded combinationally from registered `count`). A pop at edge N raises `in_ready` after edge N.
- **Push and pop with `rst` high:** both are ignored.

## Configuration
- Macro: `MUL_FIFO_STICKY_FLAGS_EN`.
- **Defined:** the sticky register is implemented as described in Operation.
- **Undefined:**
  - `sticky_flags` is tied to 4'b0000.
  - `clear_sticky` is ignored.
  - No sticky register is synthesised.
  - All other behaviour is identical.

## Test plan
- **Reset behaviour:** hold `rst`=1 for 2 cycles with `in_valid`=1, then release. Required: `count`=0, `out_valid`=0, `out_result`=0 and `in_ready`=0 during reset; `in_ready`=1 in the first cycle after release.
- **Single entry:** with `bus`=4, push `result`=4'hF, `negative`=1, other flags 0, with `out_ready`=0. Required, one cycle later: `out_valid`=1, `out_result`=4'hF, `out_flags`=4'b0010, `count`=1.
- **Fill and drain:** push results 1, 2, 3, 4 with `out_ready`=0. Required: `count`=4, `in_ready`=0, and a fifth push is not accepted. Then assert `out_ready`; required: outputs 1, 2, 3, 4 on consecutive cycles, then `out_valid`=0.
- **Wrap-around:** hold `in_valid`=1 and `out_ready`=1 for 10 cycles with results 0 to 9. Required: `count` stays at 1 after the first push, and outputs appear in order 0 to 9 with no loss across pointer wrap.
- **Sticky flags (macro defined):**
  - Push `overflow`=1, then push `zero`=1. Required: `sticky_flags`=4'b1100.
  - Then assert `clear_sticky` together with a push of `carry_out`=1. Required: `sticky_flags`=4'b0001.
  - With the macro undefined, the same stimulus must give `sticky_flags`=0 throughout.
- **Reset mid-operation:** with `count`=3, assert `rst` for 1 cycle. Required: `count`=0, `out_valid`=0, and the next push followed by a pop returns only the new entry.
